// File: rtl/control_unit_if.sv
// Control bundle between the control_unit sequencer and Datapath2: instruction/halt
// request into the sequencer, bus-driver, register-load and ALU controls out of it.
interface control_unit_if;
  logic [31:0] IR;
  logic        stop;

  logic        PCout, Zlowout, MDRout, Rout, BAout, Cout;
  logic        MARin, Zin, PCin, MDRin, IRin, Yin, Rin;
  logic        Gra, Grb, Grc;
  logic        Read, Write;
  logic [4:0]  ALU_Control;
  logic        run;

  // No valid/ready pair: controls are level signals, valid for the whole cycle of the
  // state that drives them; IR is held by the datapath from the T2->T3 edge to the next T2.
  modport master (
    input  IR, stop,
    output PCout, Zlowout, MDRout, Rout, BAout, Cout,
    output MARin, Zin, PCin, MDRin, IRin, Yin, Rin,
    output Gra, Grb, Grc, Read, Write, ALU_Control, run
  );

  modport slave (
    output IR, stop,
    input  PCout, Zlowout, MDRout, Rout, BAout, Cout,
    input  MARin, Zin, PCin, MDRin, IRin, Yin, Rin,
    input  Gra, Grb, Grc, Read, Write, ALU_Control, run
  );
endinterface

// File: rtl/control_unit.sv
// Hardwired Moore sequencer for Datapath2: fetch in T0-T2, execute in T3-T7,
// decoding IR[31:27]; stop is honoured only at the last execute state.
module control_unit #(
  parameter logic [4:0] ALU_AND = 5'd1,
  parameter logic [4:0] ALU_OR  = 5'd2,
  parameter logic [4:0] ALU_ADD = 5'd3,
  parameter logic [4:0] ALU_SUB = 5'd4,
  parameter logic [4:0] ALU_INC = 5'd12
) (
  input  logic                 clk,
  input  logic                 clr,
  control_unit_if.master       cu,
  output logic [3:0]           state_dbg
);

  typedef enum logic [3:0] {
    S_RESET = 4'd0,
    S_T0    = 4'd1,
    S_T1    = 4'd2,
    S_T2    = 4'd3,
    S_T3    = 4'd4,
    S_T4    = 4'd5,
    S_T5    = 4'd6,
    S_T6    = 4'd7,
    S_T7    = 4'd8,
    S_HALT  = 4'd9
  } state_t;

  localparam logic [4:0] OP_LD   = 5'b00000;
  localparam logic [4:0] OP_ST   = 5'b00010;
  localparam logic [4:0] OP_ADD  = 5'b00011;
  localparam logic [4:0] OP_SUB  = 5'b00100;
  localparam logic [4:0] OP_AND  = 5'b00101;
  localparam logic [4:0] OP_OR   = 5'b00110;
  localparam logic [4:0] OP_ADDI = 5'b01100;
  localparam logic [4:0] OP_ANDI = 5'b01101;
  localparam logic [4:0] OP_ORI  = 5'b01110;
  localparam logic [4:0] OP_HALT = 5'b11011;

  state_t     state, state_nxt;
  logic [4:0] opcode;
  logic       is_rtype, is_imm, is_ld, is_st, is_mem, is_halt;
  logic [4:0] alu_op;
  state_t     done_nxt;

  logic pc_out, zlow_out, mdr_out, r_out, ba_out, c_out;
  logic mar_in, z_in, pc_in, mdr_in, ir_in, y_in, r_in;
  logic gra, grb, grc, rd, wr, run;
  logic [4:0] alu_ctl;

  logic unused_ir_bits;
  assign unused_ir_bits = ^cu.IR[26:0];

  assign opcode   = cu.IR[31:27];
  assign is_rtype = (opcode == OP_ADD) || (opcode == OP_SUB) ||
                    (opcode == OP_AND) || (opcode == OP_OR);
  assign is_imm   = (opcode == OP_ADDI) || (opcode == OP_ANDI) || (opcode == OP_ORI);
  assign is_ld    = (opcode == OP_LD);
  assign is_st    = (opcode == OP_ST);
  assign is_mem   = is_ld || is_st;
  assign is_halt  = (opcode == OP_HALT);
  assign done_nxt = cu.stop ? S_HALT : S_T0;

  always_comb begin
    alu_op = 5'd0;
    case (opcode)
      OP_ADD, OP_ADDI: alu_op = ALU_ADD;
      OP_SUB:          alu_op = ALU_SUB;
      OP_AND, OP_ANDI: alu_op = ALU_AND;
      OP_OR,  OP_ORI:  alu_op = ALU_OR;
      default:         alu_op = 5'd0;
    endcase
  end

  always_ff @(posedge clk or negedge clr) begin
    if (!clr) state <= S_RESET;
    else      state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    pc_out = 1'b0; zlow_out = 1'b0; mdr_out = 1'b0; r_out = 1'b0; ba_out = 1'b0; c_out = 1'b0;
    mar_in = 1'b0; z_in = 1'b0; pc_in = 1'b0; mdr_in = 1'b0; ir_in = 1'b0; y_in = 1'b0;
    r_in = 1'b0; gra = 1'b0; grb = 1'b0; grc = 1'b0; rd = 1'b0; wr = 1'b0;
    alu_ctl = 5'd0;
    run = 1'b1;
    case (state)
      S_RESET: begin
        run = 1'b0;
        state_nxt = S_T0;
      end
      S_T0: begin
        pc_out = 1'b1; mar_in = 1'b1; z_in = 1'b1; alu_ctl = ALU_INC;
        state_nxt = S_T1;
      end
      S_T1: begin
        zlow_out = 1'b1; pc_in = 1'b1; rd = 1'b1; mdr_in = 1'b1;
        state_nxt = S_T2;
      end
      S_T2: begin
        mdr_out = 1'b1; ir_in = 1'b1;
        state_nxt = S_T3;
      end
      // Unrecognised opcodes fall to the nop path: nothing driven, instruction ends here.
      S_T3: begin
        if (is_rtype || is_imm) begin
          grb = 1'b1; r_out = 1'b1; y_in = 1'b1;
          state_nxt = S_T4;
        end else if (is_mem) begin
          grb = 1'b1; ba_out = 1'b1; y_in = 1'b1;
          state_nxt = S_T4;
        end else if (is_halt) begin
          state_nxt = S_HALT;
        end else begin
          state_nxt = done_nxt;
        end
      end
      S_T4: begin
        z_in = 1'b1;
        if (is_rtype) begin
          grc = 1'b1; r_out = 1'b1; alu_ctl = alu_op;
        end else if (is_imm) begin
          c_out = 1'b1; alu_ctl = alu_op;
        end else begin
          c_out = 1'b1; alu_ctl = ALU_ADD;
        end
        state_nxt = S_T5;
      end
      S_T5: begin
        zlow_out = 1'b1;
        if (is_mem) begin
          mar_in = 1'b1;
          state_nxt = S_T6;
        end else begin
          gra = 1'b1; r_in = 1'b1;
          state_nxt = done_nxt;
        end
      end
      S_T6: begin
        mdr_in = 1'b1;
        if (is_st) begin
          gra = 1'b1; r_out = 1'b1;
        end else begin
          rd = 1'b1;
        end
        state_nxt = S_T7;
      end
      S_T7: begin
        if (is_st) begin
          wr = 1'b1;
        end else begin
          mdr_out = 1'b1; gra = 1'b1; r_in = 1'b1;
        end
        state_nxt = done_nxt;
      end
      S_HALT: begin
        run = 1'b0;
        state_nxt = S_HALT;
      end
      default: begin
        run = 1'b0;
        state_nxt = S_RESET;
      end
    endcase
  end

  assign cu.PCout       = pc_out;
  assign cu.Zlowout     = zlow_out;
  assign cu.MDRout      = mdr_out;
  assign cu.Rout        = r_out;
  assign cu.BAout       = ba_out;
  assign cu.Cout        = c_out;
  assign cu.MARin       = mar_in;
  assign cu.Zin         = z_in;
  assign cu.PCin        = pc_in;
  assign cu.MDRin       = mdr_in;
  assign cu.IRin        = ir_in;
  assign cu.Yin         = y_in;
  assign cu.Rin         = r_in;
  assign cu.Gra         = gra;
  assign cu.Grb         = grb;
  assign cu.Grc         = grc;
  assign cu.Read        = rd;
  assign cu.Write       = wr;
  assign cu.ALU_Control = alu_ctl;
  assign cu.run         = run;
  assign state_dbg      = state;

endmodule

// File: tb/tb_control_unit.sv
// Directed bench for control_unit: walks fetch/execute of each instruction class,
// stop and halt handling, and asynchronous reset, checking all outputs every cycle.
module tb_control_unit;

  logic       clk = 1'b1;
  logic       clr;
  logic [3:0] state_dbg;
  int         checks = 0;
  int         errors = 0;

  control_unit_if bus ();

  control_unit dut (
    .clk       (clk),
    .clr       (clr),
    .cu        (bus.master),
    .state_dbg (state_dbg)
  );

  // Clock: falling edges at 5,15,...; rising edges at 10,20,...
  always #5 clk = ~clk;

  localparam logic [17:0] PCOUT   = 18'h20000;
  localparam logic [17:0] ZLOWOUT = 18'h10000;
  localparam logic [17:0] MDROUT  = 18'h08000;
  localparam logic [17:0] ROUT    = 18'h04000;
  localparam logic [17:0] BAOUT   = 18'h02000;
  localparam logic [17:0] COUT    = 18'h01000;
  localparam logic [17:0] MARIN   = 18'h00800;
  localparam logic [17:0] ZIN     = 18'h00400;
  localparam logic [17:0] PCIN    = 18'h00200;
  localparam logic [17:0] MDRIN   = 18'h00100;
  localparam logic [17:0] IRIN    = 18'h00080;
  localparam logic [17:0] YIN     = 18'h00040;
  localparam logic [17:0] RIN     = 18'h00020;
  localparam logic [17:0] GRA     = 18'h00010;
  localparam logic [17:0] GRB     = 18'h00008;
  localparam logic [17:0] GRC     = 18'h00004;
  localparam logic [17:0] READ    = 18'h00002;
  localparam logic [17:0] WRITE   = 18'h00001;
  localparam logic [17:0] NONE    = 18'h00000;

  function automatic logic [23:0] observed();
    return {bus.PCout, bus.Zlowout, bus.MDRout, bus.Rout, bus.BAout, bus.Cout,
            bus.MARin, bus.Zin, bus.PCin, bus.MDRin, bus.IRin, bus.Yin, bus.Rin,
            bus.Gra, bus.Grb, bus.Grc, bus.Read, bus.Write, bus.ALU_Control, bus.run};
  endfunction

  task automatic check(input string tag, input logic [17:0] sigs,
                       input logic [4:0] alu, input logic run_e);
    logic [23:0] obs;
    logic [23:0] exp;
    obs = observed();
    exp = {sigs, alu, run_e};
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Checks T0..T2 starting at the current T0 sample point; IR is loaded here for the
  // instruction being fetched, well before the T2->T3 edge.
  task automatic fetch(input string tag, input logic [31:0] ir);
    bus.IR = ir;
    check({tag, "_t0"}, PCOUT | MARIN | ZIN, 5'd12, 1'b1); tick();
    check({tag, "_t1"}, ZLOWOUT | PCIN | READ | MDRIN, 5'd0, 1'b1); tick();
    check({tag, "_t2"}, MDROUT | IRIN, 5'd0, 1'b1); tick();
  endtask

  task automatic alu_instr(input string tag, input logic [31:0] ir, input logic imm,
                           input logic [4:0] alu);
    fetch(tag, ir);
    check({tag, "_t3"}, GRB | ROUT | YIN, 5'd0, 1'b1); tick();
    if (imm) check({tag, "_t4"}, COUT | ZIN, alu, 1'b1);
    else     check({tag, "_t4"}, GRC | ROUT | ZIN, alu, 1'b1);
    tick();
    check({tag, "_t5"}, ZLOWOUT | GRA | RIN, 5'd0, 1'b1); tick();
  endtask

  task automatic mem_instr(input string tag, input logic [31:0] ir, input logic is_st);
    fetch(tag, ir);
    check({tag, "_t3"}, GRB | BAOUT | YIN, 5'd0, 1'b1); tick();
    check({tag, "_t4"}, COUT | ZIN, 5'd3, 1'b1); tick();
    check({tag, "_t5"}, ZLOWOUT | MARIN, 5'd0, 1'b1); tick();
    if (is_st) check({tag, "_t6"}, GRA | ROUT | MDRIN, 5'd0, 1'b1);
    else       check({tag, "_t6"}, READ | MDRIN, 5'd0, 1'b1);
    tick();
    if (is_st) check({tag, "_t7"}, WRITE, 5'd0, 1'b1);
    else       check({tag, "_t7"}, MDROUT | GRA | RIN, 5'd0, 1'b1);
    tick();
  endtask

  // Reset pulse placed between clock edges; the next rising edge enters T0.
  task automatic do_reset(input string tag);
    #1 clr = 1'b0;
    #1 check({tag, "_in_reset"}, NONE, 5'd0, 1'b0);
    #1 clr = 1'b1;
    tick();
  endtask

  initial begin
    clr     = 1'b1;
    bus.IR  = 32'h0;
    bus.stop = 1'b0;

    // Reset window 5ns..15ns
    #5 clr = 1'b0;
    #1 check("reset_assert", NONE, 5'd0, 1'b0);
    #5 check("reset_hold_edge", NONE, 5'd0, 1'b0);
    #4 clr = 1'b1;
    #1 check("reset_released", NONE, 5'd0, 1'b0);
    tick();

    alu_instr("andi", 32'h69180025, 1'b1, 5'd1);
    alu_instr("add",  32'h18000000, 1'b0, 5'd3);
    alu_instr("sub",  32'h20000000, 1'b0, 5'd4);
    alu_instr("or",   32'h30000000, 1'b0, 5'd2);
    alu_instr("and",  32'h28000000, 1'b0, 5'd1);
    alu_instr("addi", 32'h60000000, 1'b1, 5'd3);
    alu_instr("ori",  32'h70000000, 1'b1, 5'd2);
    mem_instr("ld",   32'h00000000, 1'b0);
    mem_instr("st",   32'h10000000, 1'b1);

    fetch("nop", 32'hD0000000);
    check("nop_t3", NONE, 5'd0, 1'b1); tick();
    fetch("undef", 32'hF8000000);
    check("undef_t3", NONE, 5'd0, 1'b1); tick();

    // stop raised in T4 of andi: ignored at T4->T5, honoured after T5
    fetch("stop_andi", 32'h69180025);
    check("stop_andi_t3", GRB | ROUT | YIN, 5'd0, 1'b1); tick();
    bus.stop = 1'b1;
    check("stop_andi_t4", COUT | ZIN, 5'd1, 1'b1); tick();
    check("stop_andi_t5", ZLOWOUT | GRA | RIN, 5'd0, 1'b1); tick();
    check("stop_halt", NONE, 5'd0, 1'b0); tick();
    bus.stop = 1'b0;
    check("stop_halt_hold1", NONE, 5'd0, 1'b0); tick();
    check("stop_halt_hold2", NONE, 5'd0, 1'b0);
    do_reset("rst_after_stop");

    // stop held from T3 of ld must not cut the instruction short
    fetch("stop_ld", 32'h00000000);
    bus.stop = 1'b1;
    check("stop_ld_t3", GRB | BAOUT | YIN, 5'd0, 1'b1); tick();
    check("stop_ld_t4", COUT | ZIN, 5'd3, 1'b1); tick();
    check("stop_ld_t5", ZLOWOUT | MARIN, 5'd0, 1'b1); tick();
    check("stop_ld_t6", READ | MDRIN, 5'd0, 1'b1); tick();
    check("stop_ld_t7", MDROUT | GRA | RIN, 5'd0, 1'b1); tick();
    check("stop_ld_halt", NONE, 5'd0, 1'b0);
    bus.stop = 1'b0;
    do_reset("rst_after_stop_ld");

    // halt instruction
    fetch("halt", 32'hD8000000);
    check("halt_t3", NONE, 5'd0, 1'b1); tick();
    check("halt_state", NONE, 5'd0, 1'b0); tick();
    check("halt_hold", NONE, 5'd0, 1'b0);
    do_reset("rst_after_halt");

    // clr pulse in T6 of ld clears outputs immediately, then restarts at T0
    fetch("ld_abort", 32'h00000000);
    check("ld_abort_t3", GRB | BAOUT | YIN, 5'd0, 1'b1); tick();
    check("ld_abort_t4", COUT | ZIN, 5'd3, 1'b1); tick();
    check("ld_abort_t5", ZLOWOUT | MARIN, 5'd0, 1'b1); tick();
    check("ld_abort_t6", READ | MDRIN, 5'd0, 1'b1);
    do_reset("ld_abort");
    alu_instr("post_abort_add", 32'h18000000, 1'b0, 5'd3);
    check("post_abort_t0", PCOUT | MARIN | ZIN, 5'd12, 1'b1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  // Safety bound on total run time
  initial begin
    #50000;
    errors++;
    $display("FAIL timeout observed=running expected=finished");
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
